// File: rtl/vrsm_pkg.sv
// Shared defaults for the ring-buffer family (first_ring_buffer, last_ring_buffer).
// Holds the default word width, lane count, burst length and the derived depth.
package vrsm_pkg;

  localparam int unsigned DefDataWidth   = 32;
  localparam int unsigned DefNumLane     = 2;
  localparam int unsigned DefBurstLength = 8;
  // Ring depth in words; must be a power of two so pointers wrap naturally.
  localparam int unsigned DefDepth       = DefNumLane * DefBurstLength;

endpackage

// File: rtl/last_ring_buffer.sv
// last_ring_buffer: single-word write, NUM_LANE-word parallel read ring buffer.
// Reads pop a group of NUM_LANE words (lane 0 = oldest) into a registered output.
// Every BURST_LENGTH-th accepted read is flagged with a one-cycle burst_done pulse.
//
// Ports:
//   clk        - clock, all state on rising edge
//   rst        - asynchronous active-high reset
//   wen, din   - write request and word (dropped when full)
//   ren        - read request (ignored when fewer than NUM_LANE words stored)
//   dout       - registered read group, lane 0 holds the oldest word
//   valid      - dout holds a group popped on the previous edge
//   full/empty - combinational decodes of count
//   count      - words currently stored
//   burst_done - pulse coincident with the valid of the last group of a burst
module last_ring_buffer
  import vrsm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DefDataWidth,
  parameter int unsigned NUM_LANE     = DefNumLane,
  parameter int unsigned BURST_LENGTH = DefBurstLength,
  localparam int unsigned DEPTH       = NUM_LANE * BURST_LENGTH,
  localparam int unsigned CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wen,
  input  logic [DATA_WIDTH-1:0]               din,
  input  logic                                ren,
  output logic [NUM_LANE-1:0][DATA_WIDTH-1:0] dout,
  output logic                                valid,
  output logic                                full,
  output logic                                empty,
  output logic [CNT_W-1:0]                    count,
  output logic                                burst_done
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned BC_W  = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic [BC_W-1:0]       r_burst_cnt;

  logic                                w_wr_acc;
  logic                                w_rd_acc;
  logic                                w_burst_last;
  logic [CNT_W-1:0]                    w_count_next;
  logic [NUM_LANE-1:0][DATA_WIDTH-1:0] w_rd_group;

  assign count = r_count;
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

  // Acceptance uses pre-edge count, so a write while full is dropped even if
  // a read frees space on the same edge.
  assign w_wr_acc     = wen & ~full;
  assign w_rd_acc     = ren & (r_count >= CNT_W'(NUM_LANE));
  assign w_burst_last = (r_burst_cnt == BC_W'(BURST_LENGTH - 1));

  // Pointer arithmetic wraps modulo DEPTH through the PTR_W-bit width.
  always_comb begin
    for (int i = 0; i < NUM_LANE; i++) begin
      w_rd_group[i] = r_mem[r_rptr + PTR_W'(i)];
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_wr_acc) w_count_next = w_count_next + CNT_W'(1);
    if (w_rd_acc) w_count_next = w_count_next - CNT_W'(NUM_LANE);
  end

  // Storage is not reset; only pointers and count define what is held.
  // The written slot is never among the slots being read, so a same-edge
  // write cannot leak into the group being popped.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !rst) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_burst_cnt <= '0;
      dout        <= '0;
      valid       <= 1'b0;
      burst_done  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_wr_acc) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_rd_acc) begin
        r_rptr      <= r_rptr + PTR_W'(NUM_LANE);
        dout        <= w_rd_group;
        valid       <= 1'b1;
        burst_done  <= w_burst_last;
        r_burst_cnt <= w_burst_last ? '0 : r_burst_cnt + BC_W'(1);
      end else begin
        valid      <= 1'b0;
        burst_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_last_ring_buffer.sv
// Self-checking bench for last_ring_buffer: directed table, corner sequences,
// and random traffic compared against a queue-based reference model.
module tb_last_ring_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned NL    = 2;
  localparam int unsigned BL    = 8;
  localparam int unsigned DEPTH = NL * BL;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wen;
  logic [DW-1:0]         din;
  logic                  ren;
  logic [NL-1:0][DW-1:0] dout;
  logic                  valid;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic                  burst_done;

  always #5 clk = ~clk;

  last_ring_buffer #(
    .DATA_WIDTH  (DW),
    .NUM_LANE    (NL),
    .BURST_LENGTH(BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wen       (wen),
    .din       (din),
    .ren       (ren),
    .dout      (dout),
    .valid     (valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .burst_done(burst_done)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: stored words as a FIFO queue plus burst position.
  logic [DW-1:0]         q[$];
  int                    bc;
  logic [NL-1:0][DW-1:0] m_dout;
  logic                  m_valid;
  logic                  m_bd;

  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    logic          r;
    int            e_count;
    logic          e_valid;
    logic [NL*DW-1:0] e_dout;
    logic          e_bd;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    q.delete();
    bc      = 0;
    m_dout  = '0;
    m_valid = 1'b0;
    m_bd    = 1'b0;
  endtask

  task automatic model_step(input logic w, input logic [DW-1:0] d, input logic r);
    bit rd;
    bit wr;
    rd = r && (q.size() >= NL);
    wr = w && (q.size() < DEPTH);
    if (rd) begin
      for (int i = 0; i < NL; i++) m_dout[i] = q.pop_front();
      m_valid = 1'b1;
      bc      = (bc + 1) % BL;
      m_bd    = (bc == 0);
    end else begin
      m_valid = 1'b0;
      m_bd    = 1'b0;
    end
    if (wr) q.push_back(d);
  endtask

  task automatic check_model(input string pfx);
    chk({pfx, "_count"}, 128'(count), 128'(q.size()));
    chk({pfx, "_full"}, 128'(full), 128'(q.size() == DEPTH));
    chk({pfx, "_empty"}, 128'(empty), 128'(q.size() == 0));
    chk({pfx, "_valid"}, 128'(valid), 128'(m_valid));
    chk({pfx, "_burst_done"}, 128'(burst_done), 128'(m_bd));
    chk({pfx, "_dout"}, 128'(dout), 128'(m_dout));
  endtask

  // Drive one cycle, then sample 1 time unit after the rising edge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input string pfx);
    wen = w;
    din = d;
    ren = r;
    @(posedge clk);
    #1;
    model_step(w, d, r);
    check_model(pfx);
  endtask

  // Assert reset between edges; outputs must clear before any clock edge.
  // Requests held high across the reset edge must not be accepted.
  task automatic do_reset(input string pfx);
    #3;
    rst = 1'b1;
    wen = 1'b1;
    ren = 1'b1;
    din = '1;
    #1;
    model_reset();
    check_model({pfx, "_async"});
    @(posedge clk);
    #1;
    check_model({pfx, "_edge"});
    rst = 1'b0;
    wen = 1'b0;
    ren = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wen = 1'b0;
    ren = 1'b0;
    din = '0;
    model_reset();

    // Directed table: fill to full (17th write dropped), drain as one burst.
    for (int i = 0; i < 17; i++) begin
      vecs[i] = '{w: 1'b1, d: DW'(i), r: 1'b0, e_count: (i < 16) ? i + 1 : 16,
                  e_valid: 1'b0, e_dout: '0, e_bd: 1'b0};
    end
    for (int j = 0; j < 8; j++) begin
      vecs[17 + j] = '{w: 1'b0, d: '0, r: 1'b1, e_count: 16 - 2 * (j + 1), e_valid: 1'b1,
                       e_dout: {DW'(2 * j + 1), DW'(2 * j)}, e_bd: (j == 7)};
    end
    vecs[25] = '{w: 1'b0, d: '0, r: 1'b0, e_count: 0, e_valid: 1'b0,
                 e_dout: {DW'(15), DW'(14)}, e_bd: 1'b0};

    do_reset("init");
    for (int k = 0; k < 26; k++) begin
      step(vecs[k].w, vecs[k].d, vecs[k].r, "tbl_model");
      chk("tbl_count", 128'(count), 128'(vecs[k].e_count));
      chk("tbl_valid", 128'(valid), 128'(vecs[k].e_valid));
      chk("tbl_dout", 128'(dout), 128'(vecs[k].e_dout));
      chk("tbl_burst_done", 128'(burst_done), 128'(vecs[k].e_bd));
    end
    chk("tbl_empty_end", 128'(empty), 128'(1));

    // Read with a single word stored is ignored; dout holds.
    step(1'b1, DW'(7), 1'b0, "short_wr");
    step(1'b0, '0, 1'b1, "short_rd");
    chk("short_valid", 128'(valid), 128'(0));
    chk("short_dout_held", 128'(dout), 128'({DW'(15), DW'(14)}));
    chk("short_count", 128'(count), 128'(1));

    // Full with simultaneous write and read: read wins, write dropped.
    do_reset("rst_full");
    for (int i = 0; i < 16; i++) step(1'b1, DW'(i), 1'b0, "full_fill");
    step(1'b1, DW'(99), 1'b1, "full_rw");
    chk("full_rw_dout", 128'(dout), 128'({DW'(1), DW'(0)}));
    chk("full_rw_count", 128'(count), 128'(14));

    // Concurrent traffic after a small preload; pointers wrap several times.
    do_reset("rst_conc");
    for (int i = 0; i < 4; i++) step(1'b1, DW'(200 + i), 1'b0, "conc_pre");
    for (int i = 0; i < 20; i++) step(1'b1, DW'(300 + i), 1'b1, "conc");

    // Reset mid-burst discards contents and restarts the burst count.
    do_reset("rst_mid0");
    for (int i = 0; i < 5; i++) step(1'b1, DW'(10 + i), 1'b0, "mid_wr");
    step(1'b0, '0, 1'b1, "mid_rd");
    do_reset("rst_mid");
    step(1'b1, DW'(100), 1'b0, "post_wr0");
    step(1'b1, DW'(101), 1'b0, "post_wr1");
    step(1'b0, '0, 1'b1, "post_rd");
    chk("post_rd_dout", 128'(dout), 128'({DW'(101), DW'(100)}));
    chk("post_rd_burst_done", 128'(burst_done), 128'(0));

    // Random traffic, with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset("rand_rst");
      step(($urandom % 3) != 0, DW'($urandom), ($urandom % 2) == 1, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/last_ring_buffer.md
LAST_RING_BUFFER -- requirements
Module: last_ring_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits.
REQ-002 SHALL have parameter NUM_LANE, default 2, meaning words per parallel output group.
REQ-003 SHALL have parameter BURST_LENGTH, default 8, meaning output groups per burst; DEPTH = NUM_LANE*BURST_LENGTH words, DEPTH a power of two.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 wen  input  1  write request, one word per cycle.
REQ-007 din  input  DATA_WIDTH  write word.
REQ-008 ren  input  1  read request, one NUM_LANE-word group per cycle.
REQ-009 dout  output  NUM_LANE x DATA_WIDTH  registered read group; lane 0 holds the oldest word.
REQ-010 valid  output  1  registered; dout holds a freshly popped group this cycle.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 count  output  $clog2(DEPTH)+1  words currently stored.
REQ-014 burst_done  output  1  registered one-cycle pulse with the valid of the BURST_LENGTH-th group of a burst.

Function
REQ-015 Storage SHALL be a DEPTH-word ring with write pointer wptr and read pointer rptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-016 Write accepted iff wen=1 and full=0 (pre-edge value); accepted word stored at mem[wptr], wptr += 1.
REQ-017 Write with full=1 SHALL be dropped with no state change, even when a read is accepted in the same cycle.
REQ-018 Read accepted iff ren=1 and count >= NUM_LANE (pre-edge value); dout[i] <= mem[(rptr+i) mod DEPTH] for i in 0..NUM_LANE-1, rptr += NUM_LANE, valid <= 1.
REQ-019 Read with count < NUM_LANE SHALL be ignored: valid <= 0, dout holds its previous value, rptr unchanged.
REQ-020 Read latency SHALL be one cycle: group appears on dout with valid=1 the cycle after the accepting edge.
REQ-021 Simultaneous accepted write and read SHALL update count <= count + 1 - NUM_LANE; the written word is not visible to that same read.
REQ-022 count SHALL never exceed DEPTH nor underflow.
REQ-023 Burst counter (0..BURST_LENGTH-1) SHALL increment per accepted read, wrap to 0 after BURST_LENGTH-1, and assert burst_done with that read's valid.
REQ-024 full, empty SHALL be combinational decodes of count.

Reset
REQ-025 rst=1 SHALL immediately clear wptr, rptr, count, burst counter to 0; dout to all zeros; valid and burst_done to 0 (so empty=1, full=0).
REQ-026 Reset asserted mid-burst SHALL discard all stored words; the first group after release starts a new burst.
REQ-027 No write or read SHALL be accepted on an edge where rst=1.

Structure
REQ-028 Shared package vrsm_pkg SHALL hold default DATA_WIDTH, NUM_LANE, BURST_LENGTH and the DEPTH constant, shared with first_ring_buffer.
REQ-029 Implementation SHALL be one module with inline storage; no sub-module.

Verification
REQ-030 Reset, then 16 writes din=0..15, no reads -> count=16, full=1, empty=0; 17th write dropped.
REQ-031 Following REQ-030, 8 consecutive reads -> dout={1,0},{3,2},...,{15,14} with valid=1 each cycle one cycle after each read; burst_done=1 only with {15,14}; then empty=1.
REQ-032 From empty, ren=1 with count=1 -> valid=0, dout unchanged, count stays 1.
REQ-033 Concurrent wen=1, ren=1 for 20 cycles after a preload of 4 words -> count decrements by 1 per accepted read; pointers wrap past 15 with data order preserved.
REQ-034 Full (count=16), wen=1 and ren=1 on the same edge -> read group {1,0} output, write dropped, count=14.
REQ-035 rst pulsed after 5 writes and 1 read -> all outputs reset asynchronously; next writes 100,101 then read -> dout={101,100}, burst_done=0.
